// File: rtl/cim_xbar_tile.sv
// cim_xbar_tile: behavioural compute-in-memory crossbar tile.
//   Holds an xbar_size-entry input buffer and an xbar_size x xbar_size binary weight
//   array. An i_exec pulse runs a multi-cycle matrix-vector multiply, one weight row
//   per cycle, then converts every column sum into a saturated output word.
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   i_we/i_wr_addr/i_wr_data input-buffer write (accepted in IDLE only)
//   i_w_we/i_w_row/i_w_col/i_w_data  weight-cell write (accepted in IDLE only)
//   i_exec                   start pulse, honoured in IDLE only
//   o_busy                   high while a run is in progress (MAC or CONVERT)
//   i_rd_addr/o_rd_data      registered column read, 1-cycle latency
//   o_wr_conflict            sticky: a write arrived while busy
module cim_xbar_tile #(
  parameter int unsigned xbar_size     = 128,
  parameter int unsigned datatype_size = 2,
  parameter int unsigned adc_shift     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
  input  logic [datatype_size-1:0]     i_wr_data,
  input  logic                         i_w_we,
  input  logic [$clog2(xbar_size)-1:0] i_w_row,
  input  logic [$clog2(xbar_size)-1:0] i_w_col,
  input  logic                         i_w_data,
  input  logic                         i_exec,
  output logic                         o_busy,
  input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
  output logic [datatype_size-1:0]     o_rd_data,
  output logic                         o_wr_conflict
);

  localparam int unsigned AddrW  = $clog2(xbar_size);
  // Wide enough to hold xbar_size full-scale inputs without overflow.
  localparam int unsigned AccW   = datatype_size + AddrW;
  localparam int unsigned SatMax = (1 << datatype_size) - 1;

  typedef enum logic [1:0] {StIdle, StMac, StConvert} state_e;

  state_e                   r_state;
  state_e                   w_state_next;
  logic                     w_start;

  logic [datatype_size-1:0] r_in_buf  [xbar_size];
  logic [xbar_size-1:0]     r_w       [xbar_size];
  logic [AccW-1:0]          r_acc     [xbar_size];
  logic [datatype_size-1:0] r_out_buf [xbar_size];
  logic [AccW-1:0]          w_acc_next[xbar_size];
  logic [datatype_size-1:0] w_conv    [xbar_size];
  logic [AddrW-1:0]         r_row;
  logic [datatype_size-1:0] r_rd_data;
  logic                     r_wr_conflict;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_exec) begin
          w_state_next = StMac;
          w_start      = 1'b1;
        end
      end
      StMac: begin
        if (r_row == AddrW'(xbar_size - 1)) begin
          w_state_next = StConvert;
        end
      end
      StConvert: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // One weight row per MAC cycle, applied to every column in parallel.
  always_comb begin
    for (int c = 0; c < xbar_size; c++) begin
      w_acc_next[c] = r_acc[c] + (r_w[r_row][c] ? AccW'(r_in_buf[r_row]) : AccW'(0));
    end
  end

  // ADC model: shift then clip to the output word range.
  always_comb begin
    logic [AccW-1:0] shifted;
    for (int c = 0; c < xbar_size; c++) begin
      shifted   = r_acc[c] >> adc_shift;
      w_conv[c] = (shifted > AccW'(SatMax)) ? datatype_size'(SatMax)
                                            : shifted[datatype_size-1:0];
    end
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < xbar_size; i++) begin
        r_in_buf[i]  <= '0;
        r_w[i]       <= '0;
        r_acc[i]     <= '0;
        r_out_buf[i] <= '0;
      end
      r_row         <= '0;
      r_rd_data     <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      // Reads see out_buf before any CONVERT update in the same cycle.
      r_rd_data <= r_out_buf[i_rd_addr];

      if (r_state == StIdle) begin
        if (i_we) begin
          r_in_buf[i_wr_addr] <= i_wr_data;
        end
        if (i_w_we) begin
          r_w[i_w_row][i_w_col] <= i_w_data;
        end
      end else if (i_we || i_w_we) begin
        r_wr_conflict <= 1'b1;
      end

      if (w_start) begin
        for (int i = 0; i < xbar_size; i++) begin
          r_acc[i] <= '0;
        end
        r_row <= '0;
      end else if (r_state == StMac) begin
        for (int i = 0; i < xbar_size; i++) begin
          r_acc[i] <= w_acc_next[i];
        end
        r_row <= r_row + AddrW'(1);
      end

      if (r_state == StConvert) begin
        for (int i = 0; i < xbar_size; i++) begin
          r_out_buf[i] <= w_conv[i];
        end
      end
    end
  end

  assign o_busy        = (r_state != StIdle);
  assign o_rd_data     = r_rd_data;
  assign o_wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_cim_xbar_tile.sv
// Bench for cim_xbar_tile: two instances (adc_shift 0 and 6) share all stimulus and
// are compared against a column-sum reference model.
module tb_cim_xbar_tile;

  localparam int XS = 128;
  localparam int DW = 2;
  localparam int AW = 7;
  localparam int RUN_CYCLES = XS + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_we = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_w_we = 1'b0;
  logic [AW-1:0] i_w_row = '0;
  logic [AW-1:0] i_w_col = '0;
  logic          i_w_data = 1'b0;
  logic          i_exec = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic          o_busy0, o_busy6, o_wr_conflict0, o_wr_conflict6;
  logic [DW-1:0] o_rd_data0, o_rd_data6;

  int n_cmp = 0;
  int n_err = 0;

  int m_in[XS];
  bit m_w[XS][XS];
  int m_out0[XS];
  int m_out6[XS];

  always #5 clk = ~clk;

  cim_xbar_tile #(.xbar_size(XS), .datatype_size(DW), .adc_shift(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
    .i_exec(i_exec), .o_busy(o_busy0), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data0),
    .o_wr_conflict(o_wr_conflict0)
  );

  cim_xbar_tile #(.xbar_size(XS), .datatype_size(DW), .adc_shift(6)) u_dut6 (
    .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
    .i_exec(i_exec), .o_busy(o_busy6), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data6),
    .o_wr_conflict(o_wr_conflict6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < XS; r++) begin
      m_in[r] = 0;
      m_out0[r] = 0;
      m_out6[r] = 0;
      for (int c = 0; c < XS; c++) m_w[r][c] = 1'b0;
    end
  endtask

  // Reference: out[c] = clip((sum_r w[r][c]*in[r]) >> shift, 3).
  task automatic compute_model();
    for (int c = 0; c < XS; c++) begin
      int s = 0;
      for (int r = 0; r < XS; r++) if (m_w[r][c]) s += m_in[r];
      m_out0[c] = sat(s);
      m_out6[c] = sat(s >> 6);
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
    clear_model();
  endtask

  task automatic write_in(int a, int d);
    i_we = 1'b1; i_wr_addr = AW'(a); i_wr_data = DW'(d);
    tick();
    i_we = 1'b0;
    m_in[a] = d;
  endtask

  task automatic write_w(int r, int c, bit d);
    i_w_we = 1'b1; i_w_row = AW'(r); i_w_col = AW'(c); i_w_data = d;
    tick();
    i_w_we = 1'b0;
    m_w[r][c] = d;
  endtask

  task automatic read_col(int a, output int d0, output int d6);
    i_rd_addr = AW'(a);
    tick();
    d0 = int'(o_rd_data0);
    d6 = int'(o_rd_data6);
  endtask

  // Pulses i_exec and returns the number of edges until o_busy drops (bounded).
  task automatic run_mvm(output int cyc);
    i_exec = 1'b1;
    tick();
    i_exec = 1'b0;
    compute_model();
    cyc = 0;
    while (o_busy0 && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int d0, d6;
    do_reset(2);
    n_cmp++;
    if (o_busy0 !== 1'b0 || o_busy6 !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b/%b expected 0", o_busy0, o_busy6);
    end
    n_cmp++;
    if (o_wr_conflict0 !== 1'b0 || o_wr_conflict6 !== 1'b0) begin
      n_err++; $display("FAIL reset_conflict: got %b/%b expected 0", o_wr_conflict0,
                        o_wr_conflict6);
    end
    for (int c = 0; c < XS; c++) begin
      read_col(c, d0, d6);
      n_cmp++;
      if (d0 !== 0 || d6 !== 0) begin
        n_err++; $display("FAIL reset_read col %0d: got %0d/%0d expected 0", c, d0, d6);
      end
    end
  endtask

  task automatic test_basic();
    int d0, d6;
    write_w(0, 3, 1'b1);
    write_w(1, 3, 1'b1);
    write_in(0, 1);
    write_in(1, 2);
    i_rd_addr = AW'(3);
    i_exec = 1'b1;
    tick();
    i_exec = 1'b0;
    compute_model();
    for (int k = 1; k <= RUN_CYCLES; k++) begin
      n_cmp++;
      if (o_busy0 !== 1'b1 || o_busy6 !== 1'b1) begin
        n_err++; $display("FAIL basic_busy_high edge N+%0d: got %b expected 1", k, o_busy0);
      end
      if (k == 20) begin
        n_cmp++;
        if (o_rd_data0 !== 2'd0) begin
          n_err++; $display("FAIL basic_read_during_mac: got %0d expected 0", o_rd_data0);
        end
      end
      tick();
    end
    n_cmp++;
    if (o_busy0 !== 1'b0 || o_busy6 !== 1'b0) begin
      n_err++; $display("FAIL basic_busy_fall: got %b/%b expected 0", o_busy0, o_busy6);
    end
    n_cmp++;
    if (o_rd_data0 !== 2'd0) begin
      n_err++; $display("FAIL basic_convert_cycle_read: got %0d expected 0", o_rd_data0);
    end
    tick();
    n_cmp++;
    if (int'(o_rd_data0) !== m_out0[3] || int'(o_rd_data6) !== m_out6[3]) begin
      n_err++; $display("FAIL basic_col3: got %0d/%0d expected %0d/%0d", o_rd_data0,
                        o_rd_data6, m_out0[3], m_out6[3]);
    end
    read_col(4, d0, d6);
    n_cmp++;
    if (d0 !== m_out0[4] || d6 !== m_out6[4]) begin
      n_err++; $display("FAIL basic_col4: got %0d/%0d expected %0d/%0d", d0, d6,
                        m_out0[4], m_out6[4]);
    end
  endtask

  // Second run with a stray i_exec at N+5 and an ignored in_buf write at N+10.
  task automatic test_busy_inputs();
    int k, d0, d6;
    i_exec = 1'b1;
    tick();
    compute_model();
    k = 0;
    while (o_busy0 && k < 400) begin
      k++;
      i_exec = (k == 5);
      i_we = (k == 10);
      i_wr_addr = '0;
      i_wr_data = 2'd3;
      tick();
    end
    i_exec = 1'b0;
    i_we = 1'b0;
    n_cmp++;
    if (k !== RUN_CYCLES) begin
      n_err++; $display("FAIL busy_run_length: got %0d expected %0d", k, RUN_CYCLES);
    end
    n_cmp++;
    if (o_wr_conflict0 !== 1'b1 || o_wr_conflict6 !== 1'b1) begin
      n_err++; $display("FAIL busy_conflict: got %b/%b expected 1", o_wr_conflict0,
                        o_wr_conflict6);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      n_cmp++;
      if (o_busy0 !== 1'b0) begin
        n_err++; $display("FAIL busy_no_second_run cycle %0d: got %b expected 0", j, o_busy0);
      end
    end
    read_col(3, d0, d6);
    n_cmp++;
    if (d0 !== m_out0[3] || d6 !== m_out6[3]) begin
      n_err++; $display("FAIL busy_col3: got %0d/%0d expected %0d/%0d", d0, d6,
                        m_out0[3], m_out6[3]);
    end
  endtask

  task automatic test_saturation();
    int cyc, d0, d6;
    do_reset(1);
    for (int r = 0; r < XS; r++) begin
      write_w(r, 0, 1'b1);
      write_in(r, 3);
    end
    run_mvm(cyc);
    read_col(0, d0, d6);
    n_cmp++;
    if (cyc !== RUN_CYCLES || d0 !== m_out0[0] || d6 !== m_out6[0]) begin
      n_err++; $display("FAIL sat_all3: got %0d/%0d cyc %0d expected %0d/%0d cyc %0d", d0, d6,
                        cyc, m_out0[0], m_out6[0], RUN_CYCLES);
    end
    for (int r = 0; r < XS; r++) write_in(r, 1);
    run_mvm(cyc);
    read_col(0, d0, d6);
    n_cmp++;
    if (cyc !== RUN_CYCLES || d0 !== m_out0[0] || d6 !== m_out6[0]) begin
      n_err++; $display("FAIL sat_all1: got %0d/%0d cyc %0d expected %0d/%0d cyc %0d", d0, d6,
                        cyc, m_out0[0], m_out6[0], RUN_CYCLES);
    end
  endtask

  // Random weights with density rising across columns, then an immediate second run
  // whose exec cycle also carries writes that must be included.
  task automatic test_back_to_back();
    int cyc, d0, d6, wa, wd, wr, wc;
    do_reset(1);
    for (int c = 0; c < XS; c++)
      for (int r = 0; r < XS; r++)
        if ($urandom_range(0, XS - 1) < c) write_w(r, c, 1'b1);
    for (int r = 0; r < XS; r++) write_in(r, $urandom_range(0, 3));
    run_mvm(cyc);
    n_cmp++;
    if (cyc !== RUN_CYCLES) begin
      n_err++; $display("FAIL b2b_first_len: got %0d expected %0d", cyc, RUN_CYCLES);
    end
    wa = $urandom_range(0, XS - 1);
    wd = $urandom_range(0, 3);
    wr = $urandom_range(0, XS - 1);
    wc = $urandom_range(0, XS - 1);
    i_exec = 1'b1;
    i_we = 1'b1; i_wr_addr = AW'(wa); i_wr_data = DW'(wd);
    i_w_we = 1'b1; i_w_row = AW'(wr); i_w_col = AW'(wc); i_w_data = 1'b1;
    tick();
    i_exec = 1'b0; i_we = 1'b0; i_w_we = 1'b0;
    m_in[wa] = wd;
    m_w[wr][wc] = 1'b1;
    compute_model();
    cyc = 0;
    while (o_busy0 && cyc < 400) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc !== RUN_CYCLES) begin
      n_err++; $display("FAIL b2b_second_len: got %0d expected %0d", cyc, RUN_CYCLES);
    end
    for (int c = 0; c < XS; c++) begin
      read_col(c, d0, d6);
      n_cmp++;
      if (d0 !== m_out0[c] || d6 !== m_out6[c]) begin
        n_err++; $display("FAIL b2b_col %0d: got %0d/%0d expected %0d/%0d", c, d0, d6,
                          m_out0[c], m_out6[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0, d6;
    i_exec = 1'b1;
    tick();
    i_exec = 1'b0;
    write_in(2, 1);
    repeat (47) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_model();
    n_cmp++;
    if (o_busy0 !== 1'b0 || o_busy6 !== 1'b0) begin
      n_err++; $display("FAIL midreset_busy: got %b/%b expected 0", o_busy0, o_busy6);
    end
    n_cmp++;
    if (o_wr_conflict0 !== 1'b0) begin
      n_err++; $display("FAIL midreset_conflict: got %b expected 0", o_wr_conflict0);
    end
    repeat (140) tick();
    n_cmp++;
    if (o_busy0 !== 1'b0) begin
      n_err++; $display("FAIL midreset_abandoned: got %b expected 0", o_busy0);
    end
    for (int c = 0; c < XS; c++) begin
      read_col(c, d0, d6);
      n_cmp++;
      if (d0 !== 0 || d6 !== 0) begin
        n_err++; $display("FAIL midreset_read col %0d: got %0d/%0d expected 0", c, d0, d6);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_inputs();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
